fifo_write_arbiter: RTL
=======================

# fifo_write_arbiter

Round-robin write arbiter that shares one single-clock FIFO write port between NUM_REQ producers. Each producer uses a valid/ready handshake. A granted producer keeps the write port for a burst of up to BURST_LEN beats. The arbiter drives the FIFO's write enable and data-in, and honours its full flag so the FIFO can never overflow.

## Interface
Parameters:
- DATAWIDTH, 8, payload width per requester.
- NUM_REQ, 4, number of requesters (2 to 16).
- BURST_LEN, 4, maximum beats per grant (at least 1).
- IDWIDTH, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk  input  1  single clock; all state on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester data valid.
- req_data  input  NUM_REQ*DATAWIDTH  flattened payloads; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH].
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- fifo_full  input  1  full flag from the FIFO.
- fifo_write_en  output  1  FIFO write strobe.
- fifo_data_in  output  DATAWIDTH, or DATAWIDTH+IDWIDTH with the tag feature  FIFO write data.
- grant_id  output  IDWIDTH  index of the current or last granted requester.
- busy  output  1  high while in BURST.

## Operation
- FSM has two states: IDLE and BURST.
- Reset values:
  - state IDLE, grant_id 0, beat_count 0, last_grant NUM_REQ-1.
  - req_ready 0, fifo_write_en 0, fifo_data_in 0, busy 0.
- In IDLE:
  - If any req_valid bit is set, pick the first set bit scanning upward from last_grant+1, wrapping modulo NUM_REQ.
  - Register that index into grant_id and last_grant, clear beat_count, and go to BURST.
  - If no req_valid bit is set, stay in IDLE.
  - No transfer occurs in IDLE.
- In BURST, with g = grant_id:
  - req_ready[g] = !fifo_full.
  - Beat = req_valid[g] && req_ready[g].
  - fifo_write_en = beat; fifo_data_in = req_data slice g, and is held at 0 when there is no beat.
- Beat accounting: each beat increments beat_count (width $clog2(BURST_LEN+1)).
- Return to IDLE when either:
  - a beat occurs with beat_count == BURST_LEN-1, or
  - req_valid[g] is low (the requester releases its grant; no beat that cycle).
- fifo_full high with req_valid[g] high: stall in BURST, beat_count held, burst not terminated.
- Requesters other than g see req_ready 0 at all times.
- A requester that is still valid after its burst is re-arbitrated fairly. Round robin guarantees every valid requester is granted within NUM_REQ arbitrations.
- Reset asserted mid-burst: state returns to reset values immediately (asynchronous) and no write occurs. The FIFO is reset by the same reset.

## Timing
- Arbitration latency: 1 cycle. A request arriving in IDLE at cycle t gives req_ready at t+1 and the first write at t+1.
- Peak throughput: 1 beat/cycle within a burst. Each grant costs 1 IDLE cycle, so back-to-back bursts give BURST_LEN beats per BURST_LEN+1 cycles.
- req_ready, fifo_write_en and fifo_data_in are combinational from registered state, req_valid, req_data and fifo_full. There are no registers in the data path.
- fifo_full is derived from the FIFO's registered word count, so it reflects every write up to the previous edge. A write at cycle t is therefore never issued into a full FIFO.
- FIFO usable capacity is DATADEPTH-1 words, because full asserts at DATADEPTH-1.
- The arbiter never reads the FIFO and has no dependence on read_req.

## Configuration
- FIFO_ARB_TAG_EN defined:
  - fifo_data_in = {grant_id, req_data slice}, width DATAWIDTH+IDWIDTH, tag in the MSBs.
  - The downstream FIFO must be instantiated with DATAWIDTH+IDWIDTH.
- FIFO_ARB_TAG_EN undefined:
  - fifo_data_in = payload only, width DATAWIDTH.
  - No other behaviour changes.

## Test plan
- Reset: hold reset with random inputs. Require all outputs 0, grant_id 0, busy 0. After release with req_valid=0, IDLE persists with no writes.
- Single requester: NUM_REQ=4, BURST_LEN=4, requester 2 presents 6 beats continuously (0xA0..0xA5). Required sequence:
  - 4 writes 0xA0..0xA3 on consecutive cycles.
  - 1 idle cycle.
  - 2 writes 0xA4, 0xA5.
  - Back to IDLE.
- Contention: all 4 requesters valid continuously, payload = id. Grant order 0,1,2,3,0; each burst is 4 writes of its id. Checker verifies req_ready is one-hot-or-zero every cycle.
- Full stall: fifo_full forced high for 5 cycles after beat 2 of a burst. Required:
  - no fifo_write_en and req_ready 0 during the stall;
  - beats 3 and 4 complete after release;
  - total of exactly 4 writes.
- Early release: requester 1 drops valid after 2 beats. The FSM goes to IDLE; the next grant goes to requester 2 if valid, otherwise back to 1 when it reasserts. Also assert reset mid-burst: required immediate return to IDLE and no write that cycle.
- Tag feature (FIFO_ARB_TAG_EN, NUM_REQ=4): requester 3 writes 0x5C. fifo_data_in must be 10'b11_0101_1100.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Optional macro FIFO_ARB_TAG_EN prepends the granted requester index to the FIFO word.
//   state   | meaning
//   S_IDLE  | no grant held; pick next valid requester round-robin
//   S_BURST | grant_id owns the write port for up to BURST_LEN beats
module fifo_write_arbiter #(
  parameter int DATAWIDTH = 8,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4,
  parameter int IDWIDTH   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           fifo_full,
  output logic                           fifo_write_en,
`ifdef FIFO_ARB_TAG_EN
  output logic [DATAWIDTH+IDWIDTH-1:0]   fifo_data_in,
`else
  output logic [DATAWIDTH-1:0]           fifo_data_in,
`endif
  output logic [IDWIDTH-1:0]             grant_id,
  output logic                           busy
);

  localparam int BCW = $clog2(BURST_LEN + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t             state_q, state_d;
  logic [IDWIDTH-1:0] grant_q, grant_d;
  logic [IDWIDTH-1:0] last_q, last_d;
  logic [BCW-1:0]     beat_q, beat_d;

  logic               pick_found;
  logic [IDWIDTH-1:0] pick_idx;
  logic [IDWIDTH-1:0] scan_idx;
  logic               sel_valid;
  logic [DATAWIDTH-1:0] sel_data;
  logic               beat;

  // First valid requester strictly after the last grant, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan_idx = IDWIDTH'((int'(last_q) + i) % NUM_REQ);
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign sel_valid = req_valid[grant_q];
  assign sel_data  = req_data[grant_q*DATAWIDTH +: DATAWIDTH];
  assign beat      = (state_q == S_BURST) && sel_valid && !fifo_full;

  always_comb begin
    req_ready     = '0;
    fifo_write_en = 1'b0;
    fifo_data_in  = '0;
    if (state_q == S_BURST) begin
      req_ready[grant_q] = !fifo_full;
      if (beat) begin
        fifo_write_en = 1'b1;
`ifdef FIFO_ARB_TAG_EN
        fifo_data_in  = {grant_q, sel_data};
`else
        fifo_data_in  = sel_data;
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    if (state_q == S_IDLE) begin
      if (pick_found) begin
        grant_d = pick_idx;
        last_d  = pick_idx;
        beat_d  = '0;
        state_d = S_BURST;
      end
    end else begin
      // A dropped valid releases the grant; a full FIFO only stalls.
      if (!sel_valid) begin
        state_d = S_IDLE;
      end else if (beat) begin
        beat_d = beat_q + BCW'(1);
        if (beat_q == BCW'(BURST_LEN - 1)) state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= IDWIDTH'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == S_BURST);

endmodule
